// File: rtl/buff_sched.sv
// buff_sched: round-robin scheduler feeding a fixed-latency delay buffer,
// with a tag pipe, credit check and show-ahead result FIFO.
module buff_sched #(
  parameter int DATA_W     = 32,
  parameter int BUF_STAGES = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              buf_enable,
  output logic [DATA_W-1:0] buf_in_data,
  input  logic [DATA_W-1:0] buf_out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(BUF_STAGES + 1);
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  logic [BUF_STAGES-1:0] pipe_v;
  logic [BUF_STAGES-1:0] pipe_src;
  logic [INF_W-1:0]      inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_W:0]       mem [FIFO_DEPTH];
  logic                  rr_last;

  logic             credit_ok;
  logic             grant0;
  logic             grant1;
  logic             grant;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] used;

  // Everything accepted but not yet popped must fit in the FIFO.
  assign used      = SUM_W'(inflight) + SUM_W'(fifo_count);
  assign credit_ok = !rst && (used < SUM_W'(FIFO_DEPTH));

  // Round-robin arbitration; ties go to the requester not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (credit_ok) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_last;
        grant1 = !rr_last;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign grant       = grant0 | grant1;
  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign buf_enable  = grant;
  assign buf_in_data = grant1 ? req1_data :
                       grant0 ? req0_data : '0;

  assign push      = pipe_v[BUF_STAGES-1];
  assign out_valid = !rst && (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr][DATA_W-1:0];
  assign out_src   = mem[rd_ptr][DATA_W];
  assign busy      = !rst && ((inflight != '0) || (fifo_count != '0));

  // Arbiter history; requester 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (grant) begin
      rr_last <= grant1;
    end
  end

  // Valid/source tags shadow each word through the buffer latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v   <= '0;
      pipe_src <= '0;
    end else begin
      pipe_v   <= {pipe_v[BUF_STAGES-2:0], grant};
      pipe_src <= {pipe_src[BUF_STAGES-2:0], grant1};
    end
  end

  // Count of words inside the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      unique case ({grant, push})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO storage is not reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {pipe_src[BUF_STAGES-1], buf_out_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/buff_sched.md
# buff_sched

Two-requester scheduler for the 32-bit, 6-register delay buffer (`buff_as`) in the DCT/UART datapath. Round-robin arbitration between two word sources (DCT coefficient stream, UART/config path). Each winning word goes into the buffer with `enable` high. A valid/source-tag pipeline tracks the word through the buffer's fixed latency. Results land in a show-ahead result FIFO drained by a ready/valid consumer. A credit check keeps the non-stallable buffer from overrunning the FIFO.

## Interface
- `DATA_W`, 32: word width; must equal the buffer width.
- `BUF_STAGES`, 6: register stages from buffer `in_data` to `out_data`; must equal the buffer's depth.
- `FIFO_DEPTH`, 8: result FIFO entries; power of two, at least 2.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  DATA_W  requester 0 word.
- `req0_ready`  out  1  requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as the three ports above, for requester 1.
- `buf_enable`  out  1  to buffer `enable`.
- `buf_in_data`  out  DATA_W  to buffer `in_data`.
- `buf_out_data`  in  DATA_W  from buffer `out_data`.
- `out_valid`  out  1  result FIFO non-empty.
- `out_data`  out  DATA_W  head result word.
- `out_src`  out  1  requester that issued the head word.
- `out_ready`  in  1  consumer takes head when `out_valid` is also high.
- `busy`  out  1  any word in flight or in the FIFO.

## Operation
- `credit_ok = (inflight + fifo_count) < FIFO_DEPTH`.
  - Both operands are registered values.
  - A FIFO pop in the same cycle does not raise credit until the next cycle.
- Arbitration is combinational, and only when `credit_ok` is high:
  - Only one `reqN_valid` high: grant N.
  - Both high: grant the requester not granted last (`rr_last`).
- `reqN_ready` = grant to N.
  - It depends on `reqN_valid`; a requester must not make valid depend on ready.
- `buf_enable` = any grant.
- `buf_in_data` = granted data when a grant exists, otherwise 0.
- `rr_last` updates only on a grant.
- Valid/tag pipeline: BUF_STAGES entries of {valid, src}.
  - Stage 0 loads {grant, granted src} each edge.
  - Stage k loads stage k-1.
- `inflight` counter:
  - +1 on grant, −1 when the last stage is valid.
  - Unchanged when both happen in one cycle.
  - Range 0..BUF_STAGES.
- FIFO write: when the last pipe stage is valid, push {`buf_out_data`, src} at the next edge.
- FIFO pop: `out_valid && out_ready`.
- Simultaneous push and pop: `fifo_count` unchanged, both pointers advance.
- The credit rule guarantees no push to a full FIFO.
  - Verification asserts `fifo_count <= FIFO_DEPTH` always.
  - It also asserts no push while full.
- Pointers wrap modulo FIFO_DEPTH; `fifo_count` has log2(FIFO_DEPTH)+1 bits.
- `busy = (inflight != 0) || (fifo_count != 0)`.

## Timing
- Reset (at the edge where `rst` is high):
  - Valid pipe cleared; `inflight`, `fifo_count` and both pointers set to 0.
  - `rr_last` = 1, so requester 0 wins the first tie.
- While `rst` is high:
  - `req0_ready`, `req1_ready`, `buf_enable` = 0; `buf_in_data` = 0, flushing zeros into the buffer.
  - `out_valid`, `busy` = 0; `out_data` and `out_src` are don't-care (FIFO RAM is not reset).
- Reset mid-operation: in-flight words and FIFO contents are discarded.
  - Buffer residue arriving after reset is ignored because the valid pipe is clear.
- Latency:
  - Word accepted at edge E0.
  - Buffer `out_data` holds it after edge E0+5.
  - FIFO push at E0+6.
  - `out_valid` high from E0+6 if the FIFO was empty: 6 cycles accept-to-valid.
- Throughput: one accept per cycle while credit lasts.
  - From empty with `out_ready` = 1, there is a steady stream of 1 word/cycle with no bubbles.
- With `out_ready` = 0 from reset: exactly FIFO_DEPTH words are accepted, then both readies stay 0.
- After one pop, exactly one more accept is possible, on the cycle after the pop edge.
- `out_data`, `out_src` hold stable while `out_valid && !out_ready`.

## Test plan
- Single word:
  - Stimulus: `req0` sends 0xDEADBEEF at edge 10, `out_ready` = 1.
  - Required: `out_valid` rises after edge 16 with `out_data` = 0xDEADBEEF, `out_src` = 0; `busy` low after the pop edge.
- Fairness:
  - Stimulus: both requesters hold valid; req0 sends 0x100+i, req1 sends 0x200+i, `out_ready` = 1.
  - Required: grants alternate 0,1,0,1…; req0 first after reset; output order matches grant order with correct `out_src`.
- Backpressure/credit:
  - Stimulus: `out_ready` = 0, req0 streams 1..20.
  - Required: exactly 8 accepts (words 1..8); readies stay 0.
  - Then raise `out_ready`: words 1..20 delivered in order, none lost or duplicated, FIFO never exceeds 8.
- Pop/refill boundary:
  - Stimulus: FIFO full, single pop.
  - Required: one new accept on the next cycle, none before; the count returns to 8 six cycles later.
- Reset mid-flight:
  - Stimulus: assert `rst` for 1 cycle with 3 words in the pipe and 2 in the FIFO.
  - Required: `out_valid`, `busy` = 0 after the reset edge; no stale word ever appears; the next word sent is delivered alone, 6 cycles after accept.
- Idle zeros:
  - Stimulus: no requests for 20 cycles.
  - Required: `buf_enable` = 0, `buf_in_data` = 0, `out_valid` never rises.
